ifetch_queue: RTL and testbench

Instruction fetch front end that sits between the instruction memory and the core's decode stage. Generates sequential fetch addresses, issues them to memory through a valid/ready request channel, and buffers in-order responses with their PCs in a small queue. Presents them to decode through a valid/ready handshake. A redirect from the execute stage flushes the queue, discards in-flight responses and restarts fetch at the new PC.

---
 rtl/core_pkg.sv | 10 +
 rtl/sync_fifo.sv | 50 +++++
 rtl/ifetch_queue.sv | 87 ++++++++
 tb/tb_ifetch_queue.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Types and constants shared between the fetch front end and decode.
package core_pkg;
  localparam int unsigned XLEN    = 32;
  localparam int unsigned PC_STEP = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO over registered storage, with a synchronous flush.
module sync_fifo #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [Width-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [Width-1:0]         o_rdata,
  output logic                     o_valid,
  output logic [$clog2(Depth):0]   o_count
);
  localparam int unsigned AW = $clog2(Depth);

  logic [Width-1:0] r_mem [Depth];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [AW:0]      r_count;
  logic             w_push, w_pop;

  assign w_pop  = i_pop && (r_count != '0);
  assign w_push = i_push && ((r_count != (AW+1)'(Depth)) || w_pop);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push && !i_flush) r_mem[r_wptr] <= i_wdata;
  end

  // Gate the head so an empty queue presents zeros rather than stale storage.
  assign o_valid = (r_count != '0);
  assign o_rdata = o_valid ? r_mem[r_rptr] : '0;
  assign o_count = r_count;
endmodule

// File: rtl/ifetch_queue.sv
// Fetch front end: sequential PC generation, credit-limited memory requests, response
// queue toward decode, and redirect flush with discard of in-flight responses.
module ifetch_queue
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] r_fetch_pc, r_rsp_pc;
  logic [CW-1:0]   r_outstanding, r_drop;
  logic [CW-1:0]   w_count, w_out_after_rsp;
  logic [CW:0]     w_credits;
  logic [XLEN-1:0] w_redir_pc;
  logic            w_req_fire, w_rsp_fire, w_keep, w_pop;
  fetch_entry_t    w_wentry, w_rentry;
  logic            w_unused_low;

  assign w_redir_pc   = {redirect_pc[31:2], 2'b00};
  assign w_unused_low = ^redirect_pc[1:0];

  assign w_credits     = {1'b0, w_count} + {1'b0, r_outstanding};
  assign mem_req_valid = !rst && !redirect_valid && (w_credits < (CW+1)'(DEPTH));
  assign mem_req_addr  = r_fetch_pc;
  assign w_req_fire    = mem_req_valid && mem_req_ready;

  // A response with nothing outstanding is a protocol violation and is ignored.
  assign w_rsp_fire      = mem_rsp_valid && (r_outstanding != '0);
  assign w_keep          = w_rsp_fire && (r_drop == '0) && !redirect_valid;
  assign w_pop           = instr_valid && instr_ready && !redirect_valid;
  assign w_out_after_rsp = r_outstanding - CW'(w_rsp_fire);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop        <= '0;
    end else begin
      r_outstanding <= w_out_after_rsp + CW'(w_req_fire);
      if (redirect_valid) begin
        r_fetch_pc <= w_redir_pc;
        r_rsp_pc   <= w_redir_pc;
        r_drop     <= w_out_after_rsp;
      end else begin
        if (w_req_fire) r_fetch_pc <= r_fetch_pc + XLEN'(PC_STEP);
        if (w_keep)     r_rsp_pc   <= r_rsp_pc + XLEN'(PC_STEP);
        if (w_rsp_fire && (r_drop != '0)) r_drop <= r_drop - 1'b1;
      end
    end
  end

  assign w_wentry = '{pc: r_rsp_pc, instr: mem_rsp_data};

  sync_fifo #(
    .Width($bits(fetch_entry_t)),
    .Depth(DEPTH)
  ) u_fifo (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_flush(redirect_valid),
    .i_push (w_keep),
    .i_wdata(w_wentry),
    .i_pop  (w_pop),
    .o_rdata(w_rentry),
    .o_valid(instr_valid),
    .o_count(w_count)
  );

  assign instr    = w_rentry.instr;
  assign instr_pc = w_rentry.pc;
endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue with a fixed-latency in-order memory model.
module tb_ifetch_queue;
  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk, rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;

  ifetch_queue #(.RESET_PC(RPC), .DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_ready (mem_req_ready),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    bit          rdy;
    logic        req_v;
    logic [31:0] req_a;
    logic        iv;
    logic [31:0] ipc;
  } vec_t;

  pend_t       pend[$];
  logic [31:0] req_log[$];
  logic [31:0] dlv_pc[$];
  logic [31:0] dlv_ins[$];
  int          cyc, lat, n_checks, n_fail;
  bit          spur;
  vec_t        tbl[6];

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic begin_cycle(input bit rdy, input bit mrdy, input bit redir,
                             input logic [31:0] rpc);
    @(negedge clk);
    instr_ready    = rdy;
    mem_req_ready  = mrdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    mem_rsp_valid  = 1'b0;
    mem_rsp_data   = 32'h0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = mdata(pend[0].addr);
    end else if (spur) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'hDEAD_BEEF;
    end
    #1;
  endtask

  task automatic end_cycle();
    pend_t p;
    if (mem_req_valid && mem_req_ready) begin
      req_log.push_back(mem_req_addr);
      p.addr = mem_req_addr;
      p.due  = cyc + lat;
      pend.push_back(p);
    end
    if (instr_valid && instr_ready && !redirect_valid) begin
      dlv_pc.push_back(instr_pc);
      dlv_ins.push_back(instr);
    end
    if (mem_rsp_valid && pend.size() > 0 && pend[0].due == cyc) void'(pend.pop_front());
    @(posedge clk);
    cyc++;
  endtask

  task automatic tick(input bit rdy, input bit mrdy);
    begin_cycle(rdy, mrdy, 1'b0, 32'h0);
    end_cycle();
  endtask

  task automatic assert_reset();
    @(negedge clk);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    mem_rsp_valid  = 1'b0;
    instr_ready    = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    pend.delete();
    req_log.delete();
    dlv_pc.delete();
    dlv_ins.delete();
    cyc = 0;
  endtask

  // Deliveries logged since the last reset must match expected PCs with model data.
  task automatic chk_dlv(input string name, input int idx, input logic [31:0] pc);
    chk({name, "_present"}, 32'(dlv_pc.size() > idx), 32'd1);
    if (dlv_pc.size() > idx) begin
      chk({name, "_pc"}, dlv_pc[idx], pc);
      chk({name, "_ins"}, dlv_ins[idx], mdata(pc));
    end
  endtask

  task automatic chk_req(input string name, input int idx, input logic [31:0] addr);
    chk({name, "_present"}, 32'(req_log.size() > idx), 32'd1);
    if (req_log.size() > idx) chk({name, "_addr"}, req_log[idx], addr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0; lat = 1; spur = 1'b0;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0; instr_ready = 1'b0;

    for (int i = 0; i < 6; i++) begin
      tbl[i].rdy   = 1'b1;
      tbl[i].req_v = 1'b1;
      tbl[i].req_a = RPC + 32'(4 * i);
      tbl[i].iv    = (i >= 2);
      tbl[i].ipc   = (i >= 2) ? RPC + 32'(4 * (i - 2)) : 32'h0;
    end

    // Reset state
    #3;
    chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_req_addr", mem_req_addr, RPC);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    release_reset();

    // First fetch, latency 1, decode always ready
    for (int i = 0; i < 6; i++) begin
      begin_cycle(tbl[i].rdy, 1'b1, 1'b0, 32'h0);
      chk($sformatf("ff%0d_req_valid", i), 32'(mem_req_valid), 32'(tbl[i].req_v));
      chk($sformatf("ff%0d_req_addr", i), mem_req_addr, tbl[i].req_a);
      chk($sformatf("ff%0d_instr_valid", i), 32'(instr_valid), 32'(tbl[i].iv));
      chk($sformatf("ff%0d_instr_pc", i), instr_pc, tbl[i].ipc);
      chk($sformatf("ff%0d_instr", i), instr, tbl[i].iv ? mdata(tbl[i].ipc) : 32'h0);
      end_cycle();
    end

    // Decode stall: exactly DEPTH requests, spurious response ignored, then drain
    assert_reset();
    release_reset();
    lat = 1;
    repeat (10) tick(1'b0, 1'b1);
    chk("stall_req_count", 32'(req_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk_req($sformatf("stall_req%0d", i), i, RPC + 32'(4 * i));
    begin_cycle(1'b0, 1'b1, 1'b0, 32'h0);
    chk("stall_req_valid", 32'(mem_req_valid), 32'd0);
    end_cycle();
    spur = 1'b1;
    tick(1'b0, 1'b1);
    spur = 1'b0;
    repeat (12) tick(1'b1, 1'b1);
    chk_req("stall_resume", 4, 32'h0000_0110);
    for (int i = 0; i < 6; i++) chk_dlv($sformatf("stall_dlv%0d", i), i, RPC + 32'(4 * i));

    // Redirect with two requests in flight, latency 3
    assert_reset();
    release_reset();
    lat = 3;
    repeat (2) tick(1'b1, 1'b1);
    begin_cycle(1'b1, 1'b1, 1'b1, 32'h0000_2002);
    chk("redir_no_req", 32'(mem_req_valid), 32'd0);
    end_cycle();
    repeat (12) tick(1'b1, 1'b1);
    chk_req("redir_req", 2, 32'h0000_2000);
    chk_dlv("redir_dlv0", 0, 32'h0000_2000);
    chk_dlv("redir_dlv1", 1, 32'h0000_2004);

    // Redirect coinciding with a response and a pop
    assert_reset();
    release_reset();
    lat = 1;
    repeat (4) tick(1'b1, 1'b1);
    begin_cycle(1'b1, 1'b1, 1'b1, 32'h0000_3000);
    chk("sim_pre_valid", 32'(instr_valid), 32'd1);
    end_cycle();
    begin_cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("sim_r1_instr_valid", 32'(instr_valid), 32'd0);
    chk("sim_r1_req_addr", mem_req_addr, 32'h0000_3000);
    chk("sim_r1_req_valid", 32'(mem_req_valid), 32'd1);
    end_cycle();
    begin_cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("sim_r2_instr_valid", 32'(instr_valid), 32'd0);
    end_cycle();
    begin_cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("sim_r3_instr_valid", 32'(instr_valid), 32'd1);
    chk("sim_r3_instr_pc", instr_pc, 32'h0000_3000);
    chk("sim_r3_instr", instr, mdata(32'h0000_3000));
    end_cycle();
    repeat (3) tick(1'b1, 1'b1);
    chk_dlv("sim_dlv_old", 1, 32'h0000_0104);
    chk_dlv("sim_dlv_new0", 2, 32'h0000_3000);
    chk_dlv("sim_dlv_new1", 3, 32'h0000_3004);

    // PC wrap-around
    assert_reset();
    release_reset();
    lat = 1;
    repeat (2) tick(1'b1, 1'b1);
    begin_cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    end_cycle();
    repeat (8) tick(1'b1, 1'b1);
    chk_req("wrap_req0", 2, 32'hFFFF_FFF8);
    chk_req("wrap_req1", 3, 32'hFFFF_FFFC);
    chk_req("wrap_req2", 4, 32'h0000_0000);
    chk_dlv("wrap_dlv0", 0, 32'hFFFF_FFF8);
    chk_dlv("wrap_dlv1", 1, 32'hFFFF_FFFC);
    chk_dlv("wrap_dlv2", 2, 32'h0000_0000);

    // Reset with 3 entries queued and 1 outstanding
    assert_reset();
    release_reset();
    lat = 1;
    repeat (4) tick(1'b0, 1'b1);
    @(negedge clk);
    #1;
    chk("rop_pre_instr_valid", 32'(instr_valid), 32'd1);
    chk("rop_pre_req_valid", 32'(mem_req_valid), 32'd0);
    rst = 1'b1;
    #1;
    chk("rop_instr_valid", 32'(instr_valid), 32'd0);
    chk("rop_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rop_req_addr", mem_req_addr, RPC);
    release_reset();
    begin_cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("rop_restart_valid", 32'(mem_req_valid), 32'd1);
    chk("rop_restart_addr", mem_req_addr, RPC);
    chk("rop_restart_empty", 32'(instr_valid), 32'd0);
    end_cycle();
    repeat (4) tick(1'b1, 1'b1);
    chk_dlv("rop_dlv0", 0, RPC);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
